// File: rtl/jogo_genius_param.sv
// rtl/jogo_genius_param.sv - parametrised sequence-memory game controller
// Replays ROM entries on the LEDs, then checks button presses against them.
module jogo_genius_param #(
  parameter int N_BOTOES = 4,
  parameter int ADDR_W   = 4,
  parameter int TIMEOUT  = 5000,
  parameter int T_LED    = 500,
  parameter int T_GAP    = 250
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [1:0]          nivel,
  input  logic                modo,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [N_BOTOES-1:0] mem_data,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic                pronto,
  output logic [3:0]          db_estado,
  output logic [ADDR_W-1:0]   db_rodada,
  output logic [N_BOTOES-1:0] db_jogada
);

  localparam int T_MAX_A = (TIMEOUT > T_LED) ? TIMEOUT : T_LED;
  localparam int T_MAX   = (T_MAX_A > T_GAP) ? T_MAX_A : T_GAP;
  localparam int TW      = $clog2(T_MAX + 1);

  localparam logic [TW-1:0]     TMR_ONE  = TW'(1);
  localparam logic [TW-1:0]     TMR_SAT  = {TW{1'b1}};
  localparam logic [TW-1:0]     LED_LAST = TW'(T_LED - 1);
  localparam logic [TW-1:0]     GAP_LAST = TW'(T_GAP - 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    APAGA       = 4'h3,
    ESPERA      = 4'h4,
    REGISTRA    = 4'h5,
    COMPARA     = 4'h6,
    PROXIMA     = 4'h7,
    NOVA_RODADA = 4'h8,
    FIM_GANHOU  = 4'hA,
    FIM_PERDEU  = 4'hB,
    FIM_TIMEOUT = 4'hC
  } estado_t;

  estado_t             r_estado;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_rodada;
  logic [ADDR_W-1:0]   r_alvo;
  logic [TW-1:0]       r_tmr;
  logic [TW-1:0]       r_tmo;
  logic [N_BOTOES-1:0] r_b;
  logic [N_BOTOES-1:0] r_b_prev;
  logic [N_BOTOES-1:0] r_cap;
  logic [N_BOTOES-1:0] r_jogada;
  logic                r_ganhou;
  logic                r_perdeu;
  logic                r_timeout;
  logic                r_pronto;

  logic [ADDR_W-1:0]   w_alvo;
  logic                w_press;

  // Last index of the full game: quarter, half, three-quarter or whole ROM.
  assign w_alvo  = ((ADDR_W'(nivel) + A_ONE) << (ADDR_W - 2)) - A_ONE;
  // Any-button rising edge on the registered samples; a held button never retriggers.
  assign w_press = (r_b != '0) && (r_b_prev == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= INICIAL;
      r_addr    <= '0;
      r_rodada  <= '0;
      r_alvo    <= '0;
      r_tmr     <= '0;
      r_tmo     <= '0;
      r_b       <= '0;
      r_b_prev  <= '0;
      r_cap     <= '0;
      r_jogada  <= '0;
      r_ganhou  <= 1'b0;
      r_perdeu  <= 1'b0;
      r_timeout <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_b      <= botoes;
      r_b_prev <= r_b;
      case (r_estado)
        INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
          if (jogar) r_estado <= PREPARA;
        end
        PREPARA: begin
          r_addr    <= '0;
          r_tmr     <= '0;
          r_tmo     <= '0;
          r_ganhou  <= 1'b0;
          r_perdeu  <= 1'b0;
          r_timeout <= 1'b0;
          r_pronto  <= 1'b0;
          r_jogada  <= '0;
          r_alvo    <= w_alvo;
          r_rodada  <= modo ? '0 : w_alvo;
          r_estado  <= MOSTRA;
        end
        MOSTRA: begin
          if (r_tmr == LED_LAST) begin
            r_tmr    <= '0;
            r_estado <= APAGA;
          end else if (r_tmr != TMR_SAT) begin
            r_tmr <= r_tmr + TMR_ONE;
          end
        end
        APAGA: begin
          if (r_tmr == GAP_LAST) begin
            r_tmr <= '0;
            if (r_addr == r_rodada) begin
              r_addr   <= '0;
              r_tmo    <= '0;
              r_estado <= ESPERA;
            end else begin
              r_addr   <= r_addr + A_ONE;
              r_estado <= MOSTRA;
            end
          end else if (r_tmr != TMR_SAT) begin
            r_tmr <= r_tmr + TMR_ONE;
          end
        end
        ESPERA: begin
          // A press in the expiry cycle still counts as a press.
          if (w_press) begin
            r_cap    <= r_b;
            r_estado <= REGISTRA;
          end else if (r_tmo == TMO_LAST) begin
            r_timeout <= 1'b1;
            r_pronto  <= 1'b1;
            r_estado  <= FIM_TIMEOUT;
          end else if (r_tmo != TMR_SAT) begin
            r_tmo <= r_tmo + TMR_ONE;
          end
        end
        REGISTRA: begin
          r_jogada <= r_cap;
          r_estado <= COMPARA;
        end
        COMPARA: begin
          if (r_jogada != mem_data) begin
            r_perdeu <= 1'b1;
            r_pronto <= 1'b1;
            r_estado <= FIM_PERDEU;
          end else if (r_addr == r_rodada) begin
            if (r_rodada == r_alvo) begin
              r_ganhou <= 1'b1;
              r_pronto <= 1'b1;
              r_estado <= FIM_GANHOU;
            end else begin
              r_estado <= NOVA_RODADA;
            end
          end else begin
            r_estado <= PROXIMA;
          end
        end
        PROXIMA: begin
          r_addr   <= r_addr + A_ONE;
          r_tmo    <= '0;
          r_estado <= ESPERA;
        end
        NOVA_RODADA: begin
          r_rodada <= r_rodada + A_ONE;
          r_addr   <= '0;
          r_tmr    <= '0;
          r_tmo    <= '0;
          r_estado <= MOSTRA;
        end
        default: r_estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    if (r_estado == MOSTRA)      leds = mem_data;
    else if (r_estado == ESPERA) leds = botoes;
  end

  assign mem_addr  = r_addr;
  assign ganhou    = r_ganhou;
  assign perdeu    = r_perdeu;
  assign timeout   = r_timeout;
  assign pronto    = r_pronto;
  assign db_estado = r_estado;
  assign db_rodada = r_rodada;
  assign db_jogada = r_jogada;

endmodule

// File: tb/tb_jogo_genius_param.sv
// tb/tb_jogo_genius_param.sv - scoreboard bench for jogo_genius_param
// Small timings and a fixed 16-entry ROM image.
module tb_jogo_genius_param;

  localparam int NB = 4;
  localparam int AW = 4;

  localparam logic [3:0] S_INICIAL = 4'h0;
  localparam logic [3:0] S_MOSTRA  = 4'h2;
  localparam logic [3:0] S_APAGA   = 4'h3;
  localparam logic [3:0] S_ESPERA  = 4'h4;
  localparam logic [3:0] S_REG     = 4'h5;
  localparam logic [3:0] S_COMP    = 4'h6;
  localparam logic [3:0] S_PROX    = 4'h7;
  localparam logic [3:0] S_NOVA    = 4'h8;
  localparam logic [3:0] S_GANHOU  = 4'hA;
  localparam logic [3:0] S_PERDEU  = 4'hB;
  localparam logic [3:0] S_TMO     = 4'hC;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jogar = 1'b0;
  logic          modo  = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic [1:0]    nivel  = '0;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_data;
  logic [NB-1:0] leds;
  logic [NB-1:0] db_jogada;
  logic          ganhou, perdeu, timeout, pronto;
  logic [3:0]    db_estado;
  logic [AW-1:0] db_rodada;

  logic [NB-1:0] rom [16] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1,
                              4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd1, 4'd4};

  typedef struct {
    logic [3:0]    st;
    logic [NB-1:0] jog;
  } exp_t;

  logic [NB-1:0] exp_q [$];
  exp_t          sb [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            tot;

  assign mem_data = rom[mem_addr];

  jogo_genius_param #(
    .N_BOTOES(NB), .ADDR_W(AW), .TIMEOUT(20), .T_LED(4), .T_GAP(2)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes),
    .nivel(nivel), .modo(modo), .mem_addr(mem_addr), .mem_data(mem_data),
    .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .pronto(pronto), .db_estado(db_estado), .db_rodada(db_rodada),
    .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int k = 0;
    while (db_estado != s && k < budget) begin
      tick(1);
      k++;
    end
    if (db_estado != s) chk("wait_state", 32'(db_estado), 32'(s));
  endtask

  task automatic push_disp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic watch_display(input int n, output int total);
    logic [NB-1:0] e;
    int lit, gap;
    total = 0;
    for (int i = 0; i < n; i++) begin
      wait_state(S_MOSTRA, 50);
      e = exp_q.pop_front();
      chk("disp_led", 32'(leds), 32'(e));
      chk("disp_addr", 32'(mem_addr), i);
      lit = 0;
      while (db_estado == S_MOSTRA && lit < 20) begin
        lit++;
        tick(1);
      end
      chk("lit_len", lit, 4);
      gap = 0;
      while (db_estado == S_APAGA && gap < 20) begin
        if (gap == 0) chk("gap_dark", 32'(leds), 0);
        gap++;
        tick(1);
      end
      chk("gap_len", gap, 2);
      total += lit + gap;
    end
  endtask

  task automatic play(input logic [NB-1:0] b, input logic [3:0] st);
    exp_t e;
    e.st  = st;
    e.jog = b;
    sb.push_back(e);
    botoes = b;
    tick(1);
    botoes = '0;
    tick(1);
    chk("registra", 32'(db_estado), 32'(S_REG));
    tick(1);
    chk("compara", 32'(db_estado), 32'(S_COMP));
    tick(1);
    e = sb.pop_front();
    chk("outcome", 32'(db_estado), 32'(e.st));
    chk("jogada", 32'(db_jogada), 32'(e.jog));
    if (st == S_PROX) tick(1);
  endtask

  task automatic start_game(input logic [1:0] nv, input logic md);
    nivel = nv;
    modo  = md;
    jogar = 1'b1;
    tick(1);
    jogar = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tick(2);
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_leds", 32'(leds), 0);
    chk("rst_flags", {28'd0, ganhou, perdeu, timeout, pronto}, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rodada", 32'(db_rodada), 0);
    chk("rst_jogada", 32'(db_jogada), 0);
    reset = 1'b1;
    tick(1);

    // Fixed mode, shortest game
    start_game(2'd0, 1'b0);
    push_disp(4);
    watch_display(4, tot);
    chk("fix_total", tot, 24);
    chk("fix_rodada", 32'(db_rodada), 3);
    chk("fix_espera", 32'(db_estado), 32'(S_ESPERA));
    play(4'd1, S_PROX);
    play(4'd2, S_PROX);
    play(4'd4, S_PROX);
    play(4'd8, S_GANHOU);
    chk("fix_ganhou", {30'd0, ganhou, pronto}, 3);

    // Growing rounds up to index 7
    start_game(2'd1, 1'b1);
    for (int r = 0; r < 8; r++) begin
      push_disp(r + 1);
      watch_display(r + 1, tot);
      chk("grow_total", tot, (r + 1) * 6);
      chk("grow_rodada", 32'(db_rodada), r);
      for (int i = 0; i <= r; i++)
        play(rom[i], (i < r) ? S_PROX : ((r == 7) ? S_GANHOU : S_NOVA));
    end
    chk("grow_ganhou", {30'd0, ganhou, pronto}, 3);

    // Wrong press in a full-length game
    start_game(2'd3, 1'b0);
    push_disp(16);
    watch_display(16, tot);
    chk("long_rodada", 32'(db_rodada), 15);
    play(4'd1, S_PROX);
    play(4'd2, S_PROX);
    play(4'd8, S_PERDEU);
    chk("perdeu", {30'd0, perdeu, pronto}, 3);
    botoes = 4'd1;
    tick(1);
    botoes = '0;
    tick(4);
    chk("perdeu_hold_st", 32'(db_estado), 32'(S_PERDEU));
    chk("perdeu_hold_jog", 32'(db_jogada), 8);

    // Restart, mid-game nivel change, then timeout
    start_game(2'd0, 1'b0);
    wait_state(S_MOSTRA, 5);
    chk("restart_flags", {29'd0, perdeu, timeout, pronto}, 0);
    chk("restart_jog", 32'(db_jogada), 0);
    chk("restart_addr", 32'(mem_addr), 0);
    nivel = 2'd3;
    push_disp(4);
    watch_display(4, tot);
    chk("nivel_ignored", 32'(db_estado), 32'(S_ESPERA));
    tick(19);
    chk("tmo_before_st", 32'(db_estado), 32'(S_ESPERA));
    chk("tmo_before_fl", 32'(timeout), 0);
    tick(1);
    chk("tmo_st", 32'(db_estado), 32'(S_TMO));
    chk("tmo_flag", {30'd0, timeout, pronto}, 3);

    // Button held across ESPERA entry, then one long press
    botoes = 4'd1;
    start_game(2'd0, 1'b0);
    push_disp(4);
    watch_display(4, tot);
    chk("echo", 32'(leds), 1);
    tick(5);
    chk("held_entry", 32'(db_estado), 32'(S_ESPERA));
    botoes = '0;
    tick(2);
    play(4'd1, S_PROX);
    e.st  = S_PROX;
    e.jog = 4'd2;
    sb.push_back(e);
    botoes = 4'd2;
    tick(4);
    e = sb.pop_front();
    chk("long_press_st", 32'(db_estado), 32'(e.st));
    tick(6);
    chk("long_press_once", 32'(db_estado), 32'(S_ESPERA));
    chk("long_press_jog", 32'(db_jogada), 32'(e.jog));
    botoes = '0;
    tick(1);
    play(4'd4, S_PROX);
    play(4'd8, S_GANHOU);

    // Asynchronous reset during display
    start_game(2'd0, 1'b0);
    wait_state(S_MOSTRA, 5);
    chk("pre_rst_led", 32'(leds), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_st", 32'(db_estado), 32'(S_INICIAL));
    chk("async_rst_led", 32'(leds), 0);
    chk("async_rst_fl", {31'd0, ganhou}, 0);
    tick(1);
    reset = 1'b1;
    tick(2);
    chk("post_rst_st", 32'(db_estado), 32'(S_INICIAL));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jogo_genius_param.md
Name: jogo_genius_param

Overview:
- Parametrised successor of the play-sequence game controller.
- Replays a stored sequence on the LEDs, then checks the player's button presses against it, with a per-press timeout.
- Generalised in button count, sequence depth and display timing.
- Adds a growing-round mode (round r shows and checks r+1 entries) alongside the fixed full-length mode.
- Sits between the button/LED I/O and an external sequence ROM, which it addresses through mem_addr/mem_data.

Parameters:
- N_BOTOES, 4: number of buttons/LEDs; sequence entries are one-hot of this width.
- ADDR_W, 4: sequence address width; depth is 2^ADDR_W; must be >= 2.
- TIMEOUT, 5000: cycles allowed between presses in ESPERA.
- T_LED, 500: cycles each entry is lit during display.
- T_GAP, 250: dark cycles after each displayed entry.

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- jogar, in, 1: start/restart request, sampled as a level.
- botoes, in, N_BOTOES: player buttons.
- nivel, in, 2: target length select.
- modo, in, 1: 0 = fixed full length, 1 = growing rounds.
- mem_addr, out, ADDR_W: ROM address, registered.
- mem_data, in, N_BOTOES: ROM data, combinational read of mem_addr.
- leds, out, N_BOTOES: LED drive.
- ganhou, out, 1: game won.
- perdeu, out, 1: wrong press.
- timeout, out, 1: press window expired.
- pronto, out, 1: game finished (any end state).
- db_estado, out, 4: current state code.
- db_rodada, out, ADDR_W: last index of the current round.
- db_jogada, out, N_BOTOES: last registered press.

Behaviour:
- Reset (reset=0, asynchronous): state INICIAL; all outputs, counters and registers 0.
- Target: alvo = ((nivel+1) << (ADDR_W-2)) - 1. For ADDR_W=4 this gives last index 3/7/11/15.
- nivel and modo are latched in PREPARA; changes mid-game are ignored.
- State codes: INICIAL 0, PREPARA 1, MOSTRA 2, APAGA 3, ESPERA 4, REGISTRA 5, COMPARA 6, PROXIMA 7, NOVA_RODADA 8, FIM_GANHOU A, FIM_PERDEU B, FIM_TIMEOUT C.
- INICIAL, FIM_*: jogar=1 at an edge -> PREPARA. FIM_* flags hold until then. pronto=1 in all FIM_* states.
- PREPARA (1 cycle):
  - addr=0, timers=0, ganhou/perdeu/timeout/db_jogada cleared.
  - rodada = modo ? 0 : alvo.
  - -> MOSTRA.
- MOSTRA: leds=mem_data for exactly T_LED cycles -> APAGA.
- APAGA: leds=0 for T_GAP cycles, then:
  - if addr==rodada: addr=0 -> ESPERA;
  - else addr++ -> MOSTRA.
- ESPERA:
  - leds=botoes (echo).
  - Timeout counter increments each cycle; at TIMEOUT-1 with no press -> FIM_TIMEOUT.
  - Press = botoes!=0 in this cycle and botoes==0 in the previous registered sample (edge on any-button). Holding a button registers once.
  - A button held on entry to ESPERA does not count until released and pressed again.
  - On a press -> REGISTRA.
- REGISTRA: db_jogada=botoes as sampled at the press edge -> COMPARA.
- COMPARA:
  - db_jogada != mem_data -> FIM_PERDEU. Multi-bit presses are always wrong.
  - Else if addr==rodada:
    - rodada==alvo -> FIM_GANHOU;
    - else -> NOVA_RODADA.
  - Else -> PROXIMA.
- PROXIMA: addr++, timeout counter=0 -> ESPERA.
- NOVA_RODADA: rodada++, addr=0, timers=0 -> MOSTRA (redisplay from entry 0).
- Latency:
  - Press edge sampled at edge k; REGISTRA at k+1; COMPARA at k+2.
  - FIM_* state and its flag visible after edge k+3.
  - Timeout flag visible TIMEOUT cycles after ESPERA entry or last PROXIMA.
- Priority: a press and timeout expiry in the same cycle count as a press (press wins).
- Timers are ADDR_W-independent counters sized with clog2 of max(TIMEOUT, T_LED, T_GAP)+1. Counters saturate, never wrap.
- mem_addr = addr at all times; ROM read settles within the same cycle.
- Reset mid-operation returns to INICIAL immediately, regardless of state.

Test Plan:
- Use TIMEOUT=20, T_LED=4, T_GAP=2, ADDR_W=4, N_BOTOES=4, with the ROM loaded with 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4.
- Fixed, nivel=0: reset low 1 cycle, jogar pulse.
  - -> leds show 1,2,4,8, each 4 cycles lit and 2 dark.
  - Correct presses 1,2,4,8 -> ganhou=1, pronto=1, db_estado=A three cycles after the last press.
- Growing, nivel=1:
  - -> round displays of length 1,2,...,8.
  - Correct replies each round; db_rodada steps 0..7; ganhou after 8th round.
  - Total display cycles in round r = (r+1)*6.
- Wrong press, fixed, nivel=3: presses 1,2,8 -> perdeu=1, db_jogada=8, db_estado=B; further presses ignored.
- Timeout: enter ESPERA, no press -> timeout=1, db_estado=C exactly 20 cycles after entry.
  - Separately, a held button at entry gives no registration.
  - A single press held 10 cycles registers once.
- Restart/reset:
  - jogar in FIM_PERDEU -> flags clear, new game from addr 0.
  - reset asserted during MOSTRA -> leds=0, db_estado=0 asynchronously.
  - Changing nivel mid-game does not alter alvo.
